fmul_cpa_stage: RTL and testbench
=================================

// Module: fmul_cpa_stage
// PURPOSE
//  Carry-propagate stage of the pipelined FP32 multiplier. Takes the Wallace-tree sum/carry vectors
//  and multiply-stage sideband, adds them into the 48-bit product temp_sum, and feeds the normalize stage.
//  Adder is split across two register slots (A: low half, B: high half + carry) behind a valid/ready handshake.
// PARAMETERS
//  PROD_W  48  product width (z_sum/z_carry/temp_sum)
//  SPLIT   24  bits added in slot A; PROD_W-SPLIT added in slot B with slot-A carry-in
// PORTS
//  clk          in   1       clock, all state on posedge
//  clrn         in   1       asynchronous active-low reset
//  flush        in   1       synchronous kill of all in-flight entries
//  in_valid     in   1       upstream entry present
//  in_ready     out  1       stage accepts entry this cycle
//  sign         in   1       product sign
//  exp          in   10      biased product exponent (two's complement, bit 9 = negative)
//  s_is_nan     in   1       result is NaN
//  s_is_inf     in   1       result is infinity
//  qnan_frac    in   23      quiet-NaN payload
//  z_sum        in   PROD_W  Wallace sum vector
//  z_carry      in   PROD_W  Wallace carry vector
//  out_valid    out  1       output entry present
//  out_ready    in   1       normalize stage accepts entry
//  o_sign, o_exp, o_s_is_nan, o_s_is_inf, o_qnan_frac  out  1/10/1/1/23  sideband, delayed unchanged
//  o_temp_sum   out  PROD_W  z_sum + z_carry mod 2^PROD_W
//  o_sticky     out  2       [1]=|temp_sum[22:0], [0]=|temp_sum[21:0] (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (clrn=0, async): both slot valids 0, all slot data 0 -> out_valid=0, all o_* = 0, in_ready=1.
//  - Slot A on accept: lo = z_sum[SPLIT-1:0]+z_carry[SPLIT-1:0] (SPLIT+1 bits: carry + sum);
//    store hi operands z_sum/z_carry[PROD_W-1:SPLIT] and sideband unchanged.
//  - Slot B on advance: temp_sum = {hi_sum+hi_carry+carryA, loA}; carry out of bit PROD_W-1 dropped.
//  - Latency 2 cycles accept->out_valid with out_ready held 1; throughput 1 entry/cycle.
//  - adv_B = vB & out_ready; adv_A = vA & (~vB | adv_B); in_ready = ~vA | adv_A (combinational, no skid).
//  - accept = in_valid & in_ready. vA_next = accept | (vA & ~adv_A); vB_next = adv_A | (vB & ~adv_B).
//  - Output holds stable while out_valid & ~out_ready; slot data only loads on its own enable.
//  - Simultaneous accept + advance of A in one cycle is legal (slot A reloads).
//  - flush=1: vA,vB <= 0 next edge, data regs unchanged; accept ignored that cycle; flush wins over everything.
//  - clrn deassert mid-stream: entries lost, no partial output ever presented.
//  - No arithmetic on exp or flags; NaN/Inf entries travel like any other.
// CONFIGURATION
//  FMUL_CPA_STICKY_EN defined: slot A computes |loA[22:0] and |loA[21:0] (requires SPLIT>=23),
//    carried in slot B, presented on o_sticky aligned with o_temp_sum; enables RNE rounding downstream.
//  Undefined: o_sticky tied 2'b00, no sticky registers synthesized; normalize keeps ties-to-away.
// STRUCTURE
//  fmul_pkg: PROD_W, FRAC_W=23, EXP_W=10 constants; typedef fmul_side_t {sign,exp,s_is_nan,s_is_inf,qnan_frac}.
//  Sub-module fmul_pipe_slot: parameterized-width data register + valid bit, async clrn, load enable, flush.
//    Instantiated twice (slot A, slot B); handshake logic and adders stay in fmul_cpa_stage.
// TESTING
//  1 Carry across split: z_sum=48'h8FFF_FFFF_FFFF, z_carry=48'h1, out_ready=1 -> 2 cycles later
//    out_valid=1, o_temp_sum=48'h9000_0000_0000; with STICKY_EN o_sticky=2'b00.
//  2 Back-to-back 8 entries, out_ready=1 -> in_ready stays 1, 8 consecutive out_valid cycles, in order.
//  3 Backpressure: fill then out_ready=0 for 5 cycles -> 2 entries held, in_ready=0, o_* stable; release -> drain in order.
//  4 Sideband: sign=1, exp=10'h3F0, s_is_nan=1, qnan_frac=23'h400001 -> identical values on o_* with entry.
//  5 Flush with 2 entries in flight and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
//  6 Async reset asserted mid-stream (not clock-aligned) -> out_valid=0, o_temp_sum=0 immediately; clean restart.

Source files
------------

// File: rtl/fmul_pkg.sv
// Shared constants and sideband record for the pipelined FP32 multiplier.
package fmul_pkg;

  localparam int PROD_W = 48;
  localparam int FRAC_W = 23;
  localparam int EXP_W  = 10;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic              s_is_nan;
    logic              s_is_inf;
    logic [FRAC_W-1:0] qnan_frac;
  } fmul_side_t;

  localparam int SIDE_W = $bits(fmul_side_t);

endpackage

// File: rtl/fmul_pipe_slot.sv
// One pipeline register slot: data word plus valid bit, with load/drain/flush control.
module fmul_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         flush,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Flush kills the entry but leaves data untouched; a load overrides a drain.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_load | (r_valid & ~i_drain);
      if (i_load) r_data <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_data;

endmodule

// File: rtl/fmul_cpa_stage.sv
// Two-slot carry-propagate adder for the FP32 multiplier product (low half in A, high half in B).
// Optional sticky outputs are built when FMUL_CPA_STICKY_EN is defined.
module fmul_cpa_stage
  import fmul_pkg::*;
#(
  parameter int PROD_W = fmul_pkg::PROD_W,
  parameter int SPLIT  = 24
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic              s_is_nan,
  input  logic              s_is_inf,
  input  logic [FRAC_W-1:0] qnan_frac,
  input  logic [PROD_W-1:0] z_sum,
  input  logic [PROD_W-1:0] z_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic              o_s_is_nan,
  output logic              o_s_is_inf,
  output logic [FRAC_W-1:0] o_qnan_frac,
  output logic [PROD_W-1:0] o_temp_sum,
  output logic [1:0]        o_sticky
);

  localparam int HI_W = PROD_W - SPLIT;
`ifdef FMUL_CPA_STICKY_EN
  localparam int STK_W = 2;
`else
  localparam int STK_W = 0;
`endif
  localparam int A_W = (SPLIT + 1) + 2 * HI_W + SIDE_W + STK_W;
  localparam int B_W = PROD_W + SIDE_W + STK_W;

  logic              w_va, w_vb, w_adv_a, w_adv_b, w_accept;
  fmul_side_t        w_side_in, w_a_side, w_b_side;
  logic [SPLIT:0]    w_lo, w_a_lo;
  logic [HI_W-1:0]   w_a_hs, w_a_hc, w_hi;
  logic [A_W-1:0]    w_a_d, w_a_q;
  logic [B_W-1:0]    w_b_d, w_b_q;

  assign w_adv_b  = w_vb & out_ready;
  assign w_adv_a  = w_va & (~w_vb | w_adv_b);
  assign in_ready = ~w_va | w_adv_a;
  assign w_accept = in_valid & in_ready & ~flush;

  assign w_side_in = '{sign: sign, exp: exp, s_is_nan: s_is_nan,
                       s_is_inf: s_is_inf, qnan_frac: qnan_frac};
  assign w_lo = {1'b0, z_sum[SPLIT-1:0]} + {1'b0, z_carry[SPLIT-1:0]};
  // Slot B finishes the high half using the carry captured in slot A.
  assign w_hi = w_a_hs + w_a_hc + {{(HI_W-1){1'b0}}, w_a_lo[SPLIT]};

`ifdef FMUL_CPA_STICKY_EN
  logic [1:0] w_stk_in, w_a_stk;
  assign w_stk_in = {|w_lo[22:0], |w_lo[21:0]};
  assign w_a_d = {w_lo, z_sum[PROD_W-1:SPLIT], z_carry[PROD_W-1:SPLIT], w_side_in, w_stk_in};
  assign {w_a_lo, w_a_hs, w_a_hc, w_a_side, w_a_stk} = w_a_q;
  assign w_b_d = {w_hi, w_a_lo[SPLIT-1:0], w_a_side, w_a_stk};
  assign {o_temp_sum, w_b_side, o_sticky} = w_b_q;
`else
  assign w_a_d = {w_lo, z_sum[PROD_W-1:SPLIT], z_carry[PROD_W-1:SPLIT], w_side_in};
  assign {w_a_lo, w_a_hs, w_a_hc, w_a_side} = w_a_q;
  assign w_b_d = {w_hi, w_a_lo[SPLIT-1:0], w_a_side};
  assign {o_temp_sum, w_b_side} = w_b_q;
  assign o_sticky = 2'b00;
`endif

  fmul_pipe_slot #(.W(A_W)) u_slot_a (
    .clk     (clk),
    .clrn    (clrn),
    .flush   (flush),
    .i_load  (w_accept),
    .i_drain (w_adv_a),
    .i_d     (w_a_d),
    .o_valid (w_va),
    .o_q     (w_a_q)
  );

  fmul_pipe_slot #(.W(B_W)) u_slot_b (
    .clk     (clk),
    .clrn    (clrn),
    .flush   (flush),
    .i_load  (w_adv_a),
    .i_drain (w_adv_b),
    .i_d     (w_b_d),
    .o_valid (w_vb),
    .o_q     (w_b_q)
  );

  assign out_valid   = w_vb;
  assign o_sign      = w_b_side.sign;
  assign o_exp       = w_b_side.exp;
  assign o_s_is_nan  = w_b_side.s_is_nan;
  assign o_s_is_inf  = w_b_side.s_is_inf;
  assign o_qnan_frac = w_b_side.qnan_frac;

endmodule

// File: tb/tb_fmul_cpa_stage.sv
// Directed bench for fmul_cpa_stage: hand-computed sums, handshake, flush and async reset.
module tb_fmul_cpa_stage;
  import fmul_pkg::*;

  logic        clk = 1'b0, clrn = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        sign = 1'b0, s_is_nan = 1'b0, s_is_inf = 1'b0;
  logic [9:0]  exp = '0;
  logic [22:0] qnan_frac = '0;
  logic [47:0] z_sum = '0, z_carry = '0;
  logic        in_ready, out_valid, o_sign, o_s_is_nan, o_s_is_inf;
  logic [9:0]  o_exp;
  logic [22:0] o_qnan_frac;
  logic [47:0] o_temp_sum;
  logic [1:0]  o_sticky;

  fmul_cpa_stage dut (
    .clk(clk), .clrn(clrn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .exp(exp), .s_is_nan(s_is_nan), .s_is_inf(s_is_inf), .qnan_frac(qnan_frac),
    .z_sum(z_sum), .z_carry(z_carry), .out_valid(out_valid), .out_ready(out_ready),
    .o_sign(o_sign), .o_exp(o_exp), .o_s_is_nan(o_s_is_nan), .o_s_is_inf(o_s_is_inf),
    .o_qnan_frac(o_qnan_frac), .o_temp_sum(o_temp_sum), .o_sticky(o_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] sum;
    logic [35:0] side;
    logic [1:0]  stk;
  } exp_t;

  // Operands and hand-added results (mod 2^48).
  logic [47:0] vs [0:8] = '{48'h8FFF_FFFF_FFFF, 48'h0000_00FF_FFFF, 48'hFFFF_FFFF_FFFF,
                            48'h1234_5678_9ABC, 48'h0000_0020_0000, 48'hAAAA_AAAA_AAAA,
                            48'h8000_0000_0000, 48'h0000_0080_0000, 48'h0000_0000_0003};
  logic [47:0] vc [0:8] = '{48'h0000_0000_0001, 48'h0000_0000_0001, 48'h0000_0000_0001,
                            48'h1111_1111_1111, 48'h0000_0020_0000, 48'h5555_5555_5555,
                            48'h8000_0000_0000, 48'h0000_0080_0000, 48'h0000_0000_0004};
  logic [47:0] ve [0:8] = '{48'h9000_0000_0000, 48'h0000_0100_0000, 48'h0000_0000_0000,
                            48'h2345_6789_ABCD, 48'h0000_0040_0000, 48'hFFFF_FFFF_FFFF,
                            48'h0000_0000_0000, 48'h0000_0100_0000, 48'h0000_0000_0007};

  exp_t q[$];
  int   n_checks = 0, n_errors = 0, n_out = 0, cyc = 0, first_out = -1, last_out = -1;
  int   cur = 0, acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic fmul_side_t side_of(input int i);
    fmul_side_t s;
    if (i == 8) s = '{sign: 1'b1, exp: 10'h3F0, s_is_nan: 1'b1, s_is_inf: 1'b0, qnan_frac: 23'h400001};
    else s = '{sign: i[0], exp: 10'h100 + 10'(i), s_is_nan: (i == 2), s_is_inf: (i == 3),
               qnan_frac: 23'h400000 | 23'(i)};
    return s;
  endfunction

  function automatic exp_t mk_exp(input int i);
    exp_t e;
    logic [47:0] s;
    s = ve[i];
    e.sum  = s;
    e.side = side_of(i);
`ifdef FMUL_CPA_STICKY_EN
    e.stk  = {|s[22:0], |s[21:0]};
`else
    e.stk  = 2'b00;
`endif
    return e;
  endfunction

  task automatic drive(input int i);
    fmul_side_t s;
    s = side_of(i);
    cur = i;
    z_sum = vs[i]; z_carry = vc[i];
    {sign, exp, s_is_nan, s_is_inf, qnan_frac} = s;
  endtask

  // Called right after a negedge with inputs set; observes this cycle's handshake.
  task automatic cycle();
    exp_t e;
    #1;
    if (flush) q.delete();
    else if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", {63'd0, out_valid}, 64'd0);
      else begin
        e = q.pop_front();
        chk("temp_sum", o_temp_sum, e.sum);
        chk("sideband", {o_sign, o_exp, o_s_is_nan, o_s_is_inf, o_qnan_frac}, e.side);
        chk("sticky", o_sticky, e.stk);
        $display("out #%0d cyc %0d sum %h", n_out, cyc, o_temp_sum);
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
    if (in_valid && in_ready && !flush) begin
      q.push_back(mk_exp(cur));
      acc_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int n0;
    // Reset state
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_temp_sum", o_temp_sum, 64'd0);
    chk("rst_side", {o_sign, o_exp, o_s_is_nan, o_s_is_inf, o_qnan_frac}, 64'd0);
    chk("rst_sticky", o_sticky, 64'd0);
    @(negedge clk); @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);

    // 1: carry across the split, 2-cycle latency
    out_ready = 1'b1; in_valid = 1'b1; drive(0);
    cycle();
    in_valid = 1'b0;
    n0 = n_out;
    for (int k = 0; k < 6 && n_out == n0; k++) cycle();
    chk("t1_emitted", n_out - n0, 64'd1);
    chk("t1_latency", first_out - acc_cyc, 64'd2);

    // 2: eight back-to-back entries
    first_out = -1; n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; drive(i);
      #1 chk("t2_in_ready", {63'd0, in_ready}, 64'd1);
      cycle();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    chk("t2_count", n_out - n0, 64'd8);
    chk("t2_consecutive", last_out - first_out + 1, 64'd8);

    // 3: backpressure holds two entries
    out_ready = 1'b0; in_valid = 1'b1;
    drive(3); cycle();
    drive(4); cycle();
    drive(5);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_in_ready", {63'd0, in_ready}, 64'd0);
      chk("t3_out_valid", {63'd0, out_valid}, 64'd1);
      chk("t3_hold_sum", o_temp_sum, q[0].sum);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1; n0 = n_out;
    for (int k = 0; k < 4; k++) cycle();
    chk("t3_drained", n_out - n0, 64'd2);

    // 4: sideband passes through unchanged
    in_valid = 1'b1; drive(8); cycle();
    in_valid = 1'b0; n0 = n_out;
    for (int k = 0; k < 4; k++) cycle();
    chk("t4_emitted", n_out - n0, 64'd1);

    // 5: flush with two entries in flight and in_valid high
    out_ready = 1'b0; in_valid = 1'b1;
    drive(6); cycle();
    drive(7); cycle();
    flush = 1'b1; drive(1); cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
    n0 = n_out;
    for (int k = 0; k < 4; k++) cycle();
    chk("t5_nothing", n_out - n0, 64'd0);

    // 6: async reset mid-stream, then clean restart
    in_valid = 1'b1;
    drive(0); cycle();
    drive(1); cycle();
    in_valid = 1'b0;
    #3 clrn = 1'b0;
    #1;
    chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_temp_sum", o_temp_sum, 64'd0);
    chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    @(negedge clk);
    #2 clrn = 1'b1;
    @(negedge clk);
    n0 = n_out;
    in_valid = 1'b1; drive(5); cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    chk("t6_restart", n_out - n0, 64'd1);
    chk("final_queue_empty", q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
